// File: rtl/gate_memory_master.sv
// ============================================================================
// gate_memory_master -- burst initiator for the gate memory port
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gate_memory_master #(
  parameter int DATA_SIZE   = 14,
  parameter int ADDR_SIZE   = 19,
  parameter int MEMORY_SIZE = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic [ADDR_SIZE-1:0] i_base_addr,
  input  logic [ADDR_SIZE-1:0] i_length,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  input  logic                 i_wr_valid,
  output logic                 o_wr_ready,
  output logic [DATA_SIZE-1:0] o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_rd_ready,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [DATA_SIZE-1:0] o_mem_data,
  input  logic [DATA_SIZE-1:0] i_mem_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_SIZE-1:0] c_addr_one = ADDR_SIZE'(1);
  localparam logic [ADDR_SIZE:0]   c_mem_size = (ADDR_SIZE+1)'(MEMORY_SIZE);

  state_t               r_state;
  logic                 r_mode;
  logic [ADDR_SIZE-1:0] r_base;
  logic [ADDR_SIZE-1:0] r_length;
  logic [ADDR_SIZE-1:0] r_index;

  logic [ADDR_SIZE-1:0] w_addr;
  logic [ADDR_SIZE-1:0] w_next_addr;
  logic [ADDR_SIZE-1:0] w_next_index;
  logic                 w_last;
  logic [ADDR_SIZE:0]   w_end;
  logic                 w_reject;

  assign w_addr       = r_base + r_index;
  assign w_next_addr  = w_addr + c_addr_one;
  assign w_next_index = r_index + c_addr_one;
  assign w_last       = (w_next_index == r_length);
  // One extra bit so a huge base/length cannot wrap back into the legal range
  assign w_end        = {1'b0, r_base} + {1'b0, r_length};
  assign w_reject     = (r_length == '0) || (w_end > c_mem_size);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_base      <= '0;
      r_length    <= '0;
      r_index     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_wr_ready  <= 1'b0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_read  <= 1'b0;
      o_mem_write <= 1'b0;
      o_mem_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode   <= i_mode;
            r_base   <= i_base_addr;
            r_length <= i_length;
            r_index  <= '0;
            o_busy   <= 1'b1;
            r_state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_reject) begin
            o_done  <= 1'b1;
            o_error <= 1'b1;
            r_state <= S_DONE;
          end else if (r_mode) begin
            o_mem_read <= 1'b1;
            o_mem_addr <= w_addr;
            r_state    <= S_READ;
          end else begin
            o_wr_ready <= 1'b1;
            r_state    <= S_WRITE;
          end
        end

        S_WRITE: begin
          // The strobe for an accepted beat lands in the following cycle
          if (i_wr_valid) begin
            o_mem_write <= 1'b1;
            o_mem_addr  <= w_addr;
            o_mem_data  <= i_wr_data;
            r_index     <= w_next_index;
            if (w_last) begin
              o_wr_ready <= 1'b0;
              o_done     <= 1'b1;
              r_state    <= S_DONE;
            end
          end else begin
            o_mem_write <= 1'b0;
          end
        end

        S_READ: begin
          o_mem_read <= 1'b0;
          o_rd_data  <= i_mem_data;
          o_rd_valid <= 1'b1;
          r_state    <= S_HOLD;
        end

        S_HOLD: begin
          if (i_rd_ready) begin
            o_rd_valid <= 1'b0;
            r_index    <= w_next_index;
            if (w_last) begin
              o_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              o_mem_read <= 1'b1;
              o_mem_addr <= w_next_addr;
              r_state    <= S_READ;
            end
          end
        end

        S_DONE: begin
          o_done      <= 1'b0;
          o_error     <= 1'b0;
          o_busy      <= 1'b0;
          o_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_memory_master.sv
// ============================================================================
// tb_gate_memory_master -- directed checks of gate_memory_master
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gate_memory_master;

  localparam int DW = 14;
  localparam int AW = 19;
  localparam int MS = 10;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_mode = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW-1:0] i_length = '0;
  logic          o_busy, o_done, o_error;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_wr_valid = 1'b0;
  logic          o_wr_ready;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          i_rd_ready = 1'b0;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_read, o_mem_write;
  logic [DW-1:0] o_mem_data;
  logic [DW-1:0] i_mem_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, both_cnt = 0;

  logic [DW-1:0] mem [0:MS-1];

  gate_memory_master #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .MEMORY_SIZE(MS)) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_base_addr(i_base_addr),
    .i_length   (i_length),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error),
    .i_wr_data  (i_wr_data),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .i_rd_ready (i_rd_ready),
    .o_mem_addr (o_mem_addr),
    .o_mem_read (o_mem_read),
    .o_mem_write(o_mem_write),
    .o_mem_data (o_mem_data),
    .i_mem_data (i_mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: acts on the falling edge like gate_memory
  initial for (int k = 0; k < MS; k++) mem[k] = DW'(14'h3000 + k);

  always @(negedge clk) begin
    int idx;
    idx = int'(o_mem_addr);
    if (o_mem_write && idx < MS) mem[idx] <= o_mem_data;
    if (o_mem_read && idx < MS) i_mem_data <= mem[idx];
    if (o_mem_write) wr_cnt++;
    if (o_mem_read) rd_cnt++;
    if (o_done) done_cnt++;
    if (o_mem_write && o_mem_read) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {25'd0, o_busy, o_done, o_error, o_wr_ready,
                          o_rd_valid, o_mem_read, o_mem_write}, 32'd0);
    check({tag, "_addr"}, o_mem_addr, 0);
    check({tag, "_data"}, {o_mem_data, o_rd_data}, 0);
  endtask

  task automatic do_write(input int base, input int len, input int first);
    @(negedge clk);
    i_start = 1'b1; i_mode = 1'b0; i_base_addr = AW'(base); i_length = AW'(len);
    @(negedge clk);
    i_start = 1'b0;
    check("wr_busy", o_busy, 1);
    check("wr_ready_in_check", o_wr_ready, 0);
    i_wr_valid = 1'b1; i_wr_data = DW'(first);
    @(negedge clk);
    check("wr_ready", o_wr_ready, 1);
    check("wr_no_early_strobe", o_mem_write, 0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check("wr_strobe", o_mem_write, 1);
      check("wr_addr", o_mem_addr, base + i);
      check("wr_data", o_mem_data, first + i);
      if (i == len - 1) begin
        check("wr_done", o_done, 1);
        check("wr_error", o_error, 0);
        check("wr_ready_off", o_wr_ready, 0);
        i_wr_valid = 1'b0;
      end else begin
        check("wr_not_done", o_done, 0);
        i_wr_data = DW'(first + i + 1);
      end
    end
    @(negedge clk);
    check("wr_done_pulse", o_done, 0);
    check("wr_idle_busy", o_busy, 0);
    check("wr_strobe_end", o_mem_write, 0);
  endtask

  task automatic do_read(input int base, input int len, input int first, input int stall);
    @(negedge clk);
    i_start = 1'b1; i_mode = 1'b1; i_base_addr = AW'(base); i_length = AW'(len);
    i_rd_ready = (stall == 0);
    @(negedge clk);
    i_start = 1'b0;
    check("rd_busy", o_busy, 1);
    check("rd_no_read_in_check", o_mem_read, 0);
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      check("rd_strobe", o_mem_read, 1);
      check("rd_addr", o_mem_addr, base + i);
      check("rd_valid_low", o_rd_valid, 0);
      @(negedge clk);
      check("rd_valid", o_rd_valid, 1);
      check("rd_data", o_rd_data, first + i);
      check("rd_no_strobe_hold", o_mem_read, 0);
      if (i == 0 && stall > 0) begin
        repeat (stall) begin
          @(negedge clk);
          check("bp_valid", o_rd_valid, 1);
          check("bp_data", o_rd_data, first);
          check("bp_no_read", o_mem_read, 0);
        end
        i_rd_ready = 1'b1;
      end
      @(negedge clk);
    end
    check("rd_done", o_done, 1);
    check("rd_error", o_error, 0);
    check("rd_valid_end", o_rd_valid, 0);
    @(negedge clk);
    check("rd_done_pulse", o_done, 0);
    check("rd_idle_busy", o_busy, 0);
    i_rd_ready = 1'b0;
  endtask

  task automatic do_reject(input int base, input int len, input logic mode);
    int wr0, rd0;
    wr0 = wr_cnt; rd0 = rd_cnt;
    @(negedge clk);
    i_start = 1'b1; i_mode = mode; i_base_addr = AW'(base); i_length = AW'(len);
    i_rd_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("rej_busy", o_busy, 1);
    @(negedge clk);
    check("rej_done", o_done, 1);
    check("rej_error", o_error, 1);
    check("rej_wr_ready", o_wr_ready, 0);
    check("rej_rd_valid", o_rd_valid, 0);
    @(negedge clk);
    check("rej_done_pulse", o_done, 0);
    check("rej_error_pulse", o_error, 0);
    check("rej_busy_end", o_busy, 0);
    check("rej_no_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
    i_rd_ready = 1'b0;
  endtask

  initial begin
    int done0;
    #1 i_reset = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);
    i_reset = 1'b0;

    do_write(2, 3, 'h101);
    do_read(2, 3, 'h101, 0);
    do_write(7, 3, 'h207);
    do_read(7, 3, 'h207, 5);
    do_reject(8, 3, 1'b0);
    do_reject(0, 0, 1'b1);

    // Reset in the middle of a write burst
    done0 = done_cnt;
    @(negedge clk);
    i_start = 1'b1; i_mode = 1'b0; i_base_addr = '0; i_length = AW'(3);
    @(negedge clk);
    i_start = 1'b0; i_wr_valid = 1'b1; i_wr_data = DW'(14'h055);
    @(negedge clk);
    @(negedge clk);
    check("mid_strobe", o_mem_write, 1);
    #2 i_reset = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    i_reset = 1'b0; i_wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_no_done", done_cnt - done0, 0);
    do_read(2, 3, 'h101, 0);

    check("never_both_strobes", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
